// File: rtl/dram_cache_miss_handler.sv
// DRAM cache miss handler: MSHR table, backing-memory fetch over AR/R, cache fill, processor response.
// Define MISS_HANDLER_PERF_EN to add saturating miss/stall performance counters.
module dram_cache_miss_handler #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 72,
    parameter int ID_WIDTH     = 16,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 6,
    parameter int MSHR_DEPTH   = 4,
    localparam int EW = $clog2(MSHR_DEPTH),
    localparam int LW = ADDR_WIDTH - OFFSET_WIDTH,
    localparam int TW = LW - INDEX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [ID_WIDTH-1:0]   miss_id_i,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    input  logic                  miss_is_write_i,
    output logic [EW-1:0]         mem_arid_o,
    output logic [ADDR_WIDTH-1:0] mem_araddr_o,
    output logic                  mem_arvalid_o,
    input  logic                  mem_arready_i,
    input  logic [EW-1:0]         mem_rid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_rvalid_i,
    output logic                  mem_rready_o,
    output logic                  fill_valid_o,
    input  logic                  fill_ready_i,
    output logic [INDEX_WIDTH-1:0] fill_index_o,
    output logic [TW-1:0]         fill_tag_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_WIDTH-1:0]   rsp_id_o,
    output logic                  rsp_is_write_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  err_o
`ifdef MISS_HANDLER_PERF_EN
    ,
    output logic [31:0]           perf_miss_cnt_o,
    output logic [31:0]           perf_stall_cnt_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FILL  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    state_e                state_q [MSHR_DEPTH];
    state_e                state_d [MSHR_DEPTH];
    logic [ID_WIDTH-1:0]   id_q    [MSHR_DEPTH];
    logic [ID_WIDTH-1:0]   id_d    [MSHR_DEPTH];
    logic [LW-1:0]         line_q  [MSHR_DEPTH];
    logic [LW-1:0]         line_d  [MSHR_DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [MSHR_DEPTH];
    logic [DATA_WIDTH-1:0] data_d  [MSHR_DEPTH];
    logic [MSHR_DEPTH-1:0] wr_q, wr_d;

    logic          ar_lock_q, ar_lock_d, fill_lock_q, fill_lock_d, rsp_lock_q, rsp_lock_d;
    logic [EW-1:0] ar_idx_q, ar_idx_d, fill_idx_q, fill_idx_d, rsp_idx_q, rsp_idx_d;
    logic          run_q, err_q, err_d;

    logic [MSHR_DEPTH-1:0] idle_s, issue_s, fill_s, resp_s, match_s;
    logic [LW-1:0]         miss_line_s;
    logic                  miss_ready_s, alloc_s, r_hs_s, r_ok_s;
    logic [EW-1:0]         alloc_idx_s, ar_sel_s, fill_sel_s, rsp_sel_s;
    logic                  ar_valid_s, ar_hs_s, fill_valid_s, fill_hs_s, rsp_valid_s, rsp_hs_s;
    logic                  unused_ok_s;

    assign unused_ok_s = ^miss_addr_i[OFFSET_WIDTH-1:0];

    function automatic logic [EW-1:0] lowest_idx(input logic [MSHR_DEPTH-1:0] vec);
        logic [EW-1:0] idx;
        idx = {EW{1'b0}};
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = EW'(i);
            end
        end
        return idx;
    endfunction

    // Per-entry state decode and line-match against the incoming miss
    always_comb begin
        miss_line_s = miss_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH];
        idle_s  = {MSHR_DEPTH{1'b0}};
        issue_s = {MSHR_DEPTH{1'b0}};
        fill_s  = {MSHR_DEPTH{1'b0}};
        resp_s  = {MSHR_DEPTH{1'b0}};
        match_s = {MSHR_DEPTH{1'b0}};
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            idle_s[i]  = (state_q[i] == ST_IDLE);
            issue_s[i] = (state_q[i] == ST_ISSUE);
            fill_s[i]  = (state_q[i] == ST_FILL);
            resp_s[i]  = (state_q[i] == ST_RESP);
            match_s[i] = (state_q[i] != ST_IDLE) && (line_q[i] == miss_line_s);
        end
    end

    // Allocation, channel arbitration (locked while a valid is pending) and R-beat checking
    always_comb begin
        miss_ready_s = run_q && (|idle_s) && !(|match_s);
        alloc_s      = miss_valid_i && miss_ready_s;
        alloc_idx_s  = lowest_idx(idle_s);

        ar_valid_s   = ar_lock_q || (|issue_s);
        ar_sel_s     = ar_lock_q ? ar_idx_q : lowest_idx(issue_s);
        ar_hs_s      = ar_valid_s && mem_arready_i;
        fill_valid_s = fill_lock_q || (|fill_s);
        fill_sel_s   = fill_lock_q ? fill_idx_q : lowest_idx(fill_s);
        fill_hs_s    = fill_valid_s && fill_ready_i;
        rsp_valid_s  = rsp_lock_q || (|resp_s);
        rsp_sel_s    = rsp_lock_q ? rsp_idx_q : lowest_idx(resp_s);
        rsp_hs_s     = rsp_valid_s && rsp_ready_i;

        ar_lock_d    = ar_valid_s && !mem_arready_i;
        ar_idx_d     = ar_sel_s;
        fill_lock_d  = fill_valid_s && !fill_ready_i;
        fill_idx_d   = fill_sel_s;
        rsp_lock_d   = rsp_valid_s && !rsp_ready_i;
        rsp_idx_d    = rsp_sel_s;

        r_hs_s       = mem_rvalid_i && run_q;
        r_ok_s       = r_hs_s && (state_q[mem_rid_i] == ST_WAIT);
        err_d        = r_hs_s && !r_ok_s;
    end

    // Per-entry next state; a stray R beat leaves every entry untouched
    always_comb begin
        wr_d = wr_q;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            state_d[i] = state_q[i];
            id_d[i]    = id_q[i];
            line_d[i]  = line_q[i];
            data_d[i]  = data_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (alloc_s && (alloc_idx_s == EW'(i))) begin
                        state_d[i] = ST_ISSUE;
                        id_d[i]    = miss_id_i;
                        line_d[i]  = miss_line_s;
                        wr_d[i]    = miss_is_write_i;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (ar_hs_s && (ar_sel_s == EW'(i))) begin
                        state_d[i] = ST_WAIT;
                    end else begin
                        state_d[i] = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (r_ok_s && (mem_rid_i == EW'(i))) begin
                        state_d[i] = ST_FILL;
                        data_d[i]  = mem_rdata_i;
                    end else begin
                        state_d[i] = ST_WAIT;
                    end
                end
                ST_FILL: begin
                    if (fill_hs_s && (fill_sel_s == EW'(i))) begin
                        state_d[i] = ST_RESP;
                    end else begin
                        state_d[i] = ST_FILL;
                    end
                end
                ST_RESP: begin
                    if (rsp_hs_s && (rsp_sel_s == EW'(i))) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        state_d[i] = ST_RESP;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // MSHR table registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= {MSHR_DEPTH{1'b0}};
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                state_q[i] <= ST_IDLE;
                id_q[i]    <= {ID_WIDTH{1'b0}};
                line_q[i]  <= {LW{1'b0}};
                data_q[i]  <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            wr_q <= wr_d;
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                state_q[i] <= state_d[i];
                id_q[i]    <= id_d[i];
                line_q[i]  <= line_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    // Channel locks, error pulse and the out-of-reset flag that drives rready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_lock_q   <= 1'b0;
            ar_idx_q    <= {EW{1'b0}};
            fill_lock_q <= 1'b0;
            fill_idx_q  <= {EW{1'b0}};
            rsp_lock_q  <= 1'b0;
            rsp_idx_q   <= {EW{1'b0}};
            err_q       <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            ar_lock_q   <= ar_lock_d;
            ar_idx_q    <= ar_idx_d;
            fill_lock_q <= fill_lock_d;
            fill_idx_q  <= fill_idx_d;
            rsp_lock_q  <= rsp_lock_d;
            rsp_idx_q   <= rsp_idx_d;
            err_q       <= err_d;
            run_q       <= 1'b1;
        end
    end

    // Output payloads are forced to zero whenever their valid is low
    always_comb begin
        miss_ready_o  = miss_ready_s;
        mem_rready_o  = run_q;
        err_o         = err_q;
        mem_arvalid_o = ar_valid_s;
        fill_valid_o  = fill_valid_s;
        rsp_valid_o   = rsp_valid_s;
        if (ar_valid_s) begin
            mem_arid_o   = ar_sel_s;
            mem_araddr_o = {line_q[ar_sel_s], {OFFSET_WIDTH{1'b0}}};
        end else begin
            mem_arid_o   = {EW{1'b0}};
            mem_araddr_o = {ADDR_WIDTH{1'b0}};
        end
        if (fill_valid_s) begin
            fill_index_o = line_q[fill_sel_s][INDEX_WIDTH-1:0];
            fill_tag_o   = line_q[fill_sel_s][LW-1:INDEX_WIDTH];
            fill_data_o  = data_q[fill_sel_s];
        end else begin
            fill_index_o = {INDEX_WIDTH{1'b0}};
            fill_tag_o   = {TW{1'b0}};
            fill_data_o  = {DATA_WIDTH{1'b0}};
        end
        if (rsp_valid_s) begin
            rsp_id_o       = id_q[rsp_sel_s];
            rsp_is_write_o = wr_q[rsp_sel_s];
            rsp_data_o     = wr_q[rsp_sel_s] ? {DATA_WIDTH{1'b0}} : data_q[rsp_sel_s];
        end else begin
            rsp_id_o       = {ID_WIDTH{1'b0}};
            rsp_is_write_o = 1'b0;
            rsp_data_o     = {DATA_WIDTH{1'b0}};
        end
    end

`ifdef MISS_HANDLER_PERF_EN
    logic [31:0] perf_miss_q, perf_miss_d, perf_stall_q, perf_stall_d;

    // Saturating counters: accepted misses and stalled request cycles
    always_comb begin
        if (alloc_s && (perf_miss_q != 32'hFFFF_FFFF)) begin
            perf_miss_d = perf_miss_q + 32'd1;
        end else begin
            perf_miss_d = perf_miss_q;
        end
        if (miss_valid_i && !miss_ready_s && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Counter registers, cleared only by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_miss_q  <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_miss_q  <= perf_miss_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_miss_cnt_o  = perf_miss_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_dram_cache_miss_handler.sv
// Directed bench for dram_cache_miss_handler: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_dram_cache_miss_handler;
    localparam int AW = 64, DW = 72, IW = 16, XW = 4, OW = 6, MD = 4, EW = 2, TW = AW - OW - XW;
    localparam logic [DW-1:0] D1  = 72'hAB_1122_3344_5566_77CD;
    localparam logic [DW-1:0] D2  = 72'h5A_0F0F_0F0F_0F0F_0F0F;
    localparam logic [DW-1:0] DC0 = 72'h10_0000_0000_0000_0A00;
    localparam logic [DW-1:0] DC1 = 72'h11_0000_0000_0000_0A11;
    localparam logic [DW-1:0] DC2 = 72'h12_0000_0000_0000_0A22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          miss_valid_i, miss_ready_o, miss_is_write_i;
    logic [IW-1:0] miss_id_i;
    logic [AW-1:0] miss_addr_i;
    logic [EW-1:0] mem_arid_o, mem_rid_i;
    logic [AW-1:0] mem_araddr_o;
    logic          mem_arvalid_o, mem_arready_i, mem_rvalid_i, mem_rready_o;
    logic [DW-1:0] mem_rdata_i, fill_data_o, rsp_data_o;
    logic          fill_valid_o, fill_ready_i, rsp_valid_o, rsp_ready_i, rsp_is_write_o, err_o;
    logic [XW-1:0] fill_index_o;
    logic [TW-1:0] fill_tag_o;
    logic [IW-1:0] rsp_id_o;

    dram_cache_miss_handler dut (
        .clk(clk), .rst(rst),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_id_i(miss_id_i),
        .miss_addr_i(miss_addr_i), .miss_is_write_i(miss_is_write_i),
        .mem_arid_o(mem_arid_o), .mem_araddr_o(mem_araddr_o), .mem_arvalid_o(mem_arvalid_o),
        .mem_arready_i(mem_arready_i), .mem_rid_i(mem_rid_i), .mem_rdata_i(mem_rdata_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
        .fill_valid_o(fill_valid_o), .fill_ready_i(fill_ready_i), .fill_index_o(fill_index_o),
        .fill_tag_o(fill_tag_o), .fill_data_o(fill_data_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_is_write_o(rsp_is_write_o), .rsp_data_o(rsp_data_o), .err_o(err_o)
    );

    typedef struct {
        logic mv; logic [IW-1:0] mid; logic [AW-1:0] maddr; logic mwr;
        logic arready; logic rvalid; logic [EW-1:0] rid; logic [DW-1:0] rdata;
        logic fready; logic rsready;
        logic e_mready; logic e_arvalid; logic [EW-1:0] e_arid; logic [AW-1:0] e_araddr;
        logic e_fvalid; logic [XW-1:0] e_findex; logic [TW-1:0] e_ftag; logic [DW-1:0] e_fdata;
        logic e_rsvalid; logic [IW-1:0] e_rsid; logic e_rswr; logic [DW-1:0] e_rsdata;
        logic e_err; logic e_rready;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t base();
        vec_t v;
        v = '{default: '0};
        v.arready = 1'b1; v.fready = 1'b1; v.rsready = 1'b1;
        v.e_mready = 1'b1; v.e_rready = 1'b1;
        return v;
    endfunction

    task automatic idle_in();
        miss_valid_i = 1'b0; miss_id_i = '0; miss_addr_i = '0; miss_is_write_i = 1'b0;
        mem_arready_i = 1'b1; mem_rvalid_i = 1'b0; mem_rid_i = '0; mem_rdata_i = '0;
        fill_ready_i = 1'b1; rsp_ready_i = 1'b1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        chk("rst.rready", mem_rready_o, 1'b0);
        chk("rst.miss_ready", miss_ready_o, 1'b0);
        chk("rst.arvalid", mem_arvalid_o, 1'b0);
        chk("rst.araddr", mem_araddr_o, 64'h0);
        chk("rst.fill_valid", fill_valid_o, 1'b0);
        chk("rst.rsp_valid", rsp_valid_o, 1'b0);
        chk("rst.rsp_data", rsp_data_o, 72'h0);
        chk("rst.err", err_o, 1'b0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        nxt();
    endtask

    task automatic apply(input vec_t v);
        miss_valid_i = v.mv; miss_id_i = v.mid; miss_addr_i = v.maddr; miss_is_write_i = v.mwr;
        mem_arready_i = v.arready; mem_rvalid_i = v.rvalid; mem_rid_i = v.rid; mem_rdata_i = v.rdata;
        fill_ready_i = v.fready; rsp_ready_i = v.rsready;
    endtask

    task automatic cmp_vec(input int k, input vec_t v);
        chk($sformatf("v%0d.miss_ready", k), miss_ready_o, v.e_mready);
        chk($sformatf("v%0d.arvalid", k), mem_arvalid_o, v.e_arvalid);
        chk($sformatf("v%0d.arid", k), mem_arid_o, v.e_arid);
        chk($sformatf("v%0d.araddr", k), mem_araddr_o, v.e_araddr);
        chk($sformatf("v%0d.fill_valid", k), fill_valid_o, v.e_fvalid);
        chk($sformatf("v%0d.fill_index", k), fill_index_o, v.e_findex);
        chk($sformatf("v%0d.fill_tag", k), fill_tag_o, v.e_ftag);
        chk($sformatf("v%0d.fill_data", k), fill_data_o, v.e_fdata);
        chk($sformatf("v%0d.rsp_valid", k), rsp_valid_o, v.e_rsvalid);
        chk($sformatf("v%0d.rsp_id", k), rsp_id_o, v.e_rsid);
        chk($sformatf("v%0d.rsp_is_write", k), rsp_is_write_o, v.e_rswr);
        chk($sformatf("v%0d.rsp_data", k), rsp_data_o, v.e_rsdata);
        chk($sformatf("v%0d.err", k), err_o, v.e_err);
        chk($sformatf("v%0d.rready", k), mem_rready_o, v.e_rready);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int acc_cyc, rsp_cyc, nf, nr;
        logic [TW-1:0] ftags [3];
        logic [DW-1:0] fdatas [3];
        int fill_cyc [3];

        // ---- per-cycle table: read miss then write miss, all readies high ----
        v = base(); v.e_mready = 1'b0; v.e_rready = 1'b0; tbl.push_back(v);           // first cycle out of reset
        v = base(); v.mv = 1'b1; v.mid = 16'h00A5; v.maddr = 64'h1040; tbl.push_back(v);
        v = base(); v.e_arvalid = 1'b1; v.e_arid = 2'd0; v.e_araddr = 64'h1040; tbl.push_back(v);
        v = base(); tbl.push_back(v);
        v = base(); tbl.push_back(v);
        v = base(); v.rvalid = 1'b1; v.rid = 2'd0; v.rdata = D1; tbl.push_back(v);
        v = base(); v.e_fvalid = 1'b1; v.e_findex = 4'd1; v.e_ftag = TW'(4); v.e_fdata = D1; tbl.push_back(v);
        v = base(); v.e_rsvalid = 1'b1; v.e_rsid = 16'h00A5; v.e_rsdata = D1; tbl.push_back(v);
        v = base(); tbl.push_back(v);
        v = base(); v.mv = 1'b1; v.mid = 16'h0003; v.maddr = 64'h2000; v.mwr = 1'b1; tbl.push_back(v);
        v = base(); v.e_arvalid = 1'b1; v.e_arid = 2'd0; v.e_araddr = 64'h2000; tbl.push_back(v);
        v = base(); v.rvalid = 1'b1; v.rid = 2'd0; v.rdata = D2; tbl.push_back(v);
        v = base(); v.e_fvalid = 1'b1; v.e_findex = 4'd0; v.e_ftag = TW'(8); v.e_fdata = D2; tbl.push_back(v);
        v = base(); v.e_rsvalid = 1'b1; v.e_rsid = 16'h0003; v.e_rswr = 1'b1; v.e_rsdata = '0; tbl.push_back(v);
        v = base(); tbl.push_back(v);

        idle_in();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("init.rready", mem_rready_o, 1'b0);
        chk("init.arvalid", mem_arvalid_o, 1'b0);
        chk("init.fill_valid", fill_valid_o, 1'b0);
        chk("init.rsp_valid", rsp_valid_o, 1'b0);
        chk("init.err", err_o, 1'b0);
        nxt();
        rst = 1'b0;
        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k]);
            @(negedge clk);
            cmp_vec(k, tbl[k]);
            nxt();
        end

        // ---- full table: four misses with AR blocked, fifth waits for first retirement ----
        do_reset();
        mem_arready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            miss_valid_i = 1'b1; miss_id_i = IW'(k + 1); miss_addr_i = AW'(k + 1) << 16;
            @(negedge clk);
            chk($sformatf("full.ready%0d", k), miss_ready_o, 1'b1);
            nxt();
        end
        miss_id_i = 16'h0005; miss_addr_i = 64'h5_0000;
        @(negedge clk);
        chk("full.ready_when_full", miss_ready_o, 1'b0);
        chk("full.arid_first", mem_arid_o, 2'd0);
        nxt();
        mem_arready_i = 1'b1;
        acc_cyc = -1; rsp_cyc = -1;
        for (int cyc = 0; cyc < 30 && acc_cyc < 0; cyc++) begin
            mem_rvalid_i = (cyc == 1); mem_rid_i = 2'd0; mem_rdata_i = D1;
            @(negedge clk);
            if (rsp_valid_o && rsp_cyc < 0) begin
                rsp_cyc = cyc;
                chk("full.rsp_id", rsp_id_o, 16'h0001);
            end
            if (miss_ready_o) acc_cyc = cyc;
            nxt();
        end
        chk("full.accept_cycle", acc_cyc, 4);
        chk("full.rsp_cycle", rsp_cyc, 3);
        miss_valid_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("full.fifth_arid", mem_arid_o, 2'd0);
        chk("full.fifth_araddr", mem_araddr_o, 64'h5_0000);
        nxt();

        // ---- same-line miss stalls until the owning entry has retired ----
        do_reset();
        miss_valid_i = 1'b1; miss_id_i = 16'h0011; miss_addr_i = 64'h1040;
        @(negedge clk);
        chk("line.first_ready", miss_ready_o, 1'b1);
        nxt();
        miss_id_i = 16'h0022; miss_addr_i = 64'h1058;
        for (int cyc = 0; cyc < 7; cyc++) begin
            mem_rvalid_i = (cyc == 3); mem_rid_i = 2'd0; mem_rdata_i = D2;
            @(negedge clk);
            chk($sformatf("line.ready_c%0d", cyc), miss_ready_o, cyc == 6);
            if (cyc == 5) chk("line.rsp_id", rsp_valid_o ? rsp_id_o : 16'hFFFF, 16'h0011);
            nxt();
        end
        miss_valid_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("line.second_arid", mem_arid_o, 2'd0);
        chk("line.second_araddr", mem_araddr_o, 64'h1040);
        nxt();

        // ---- out-of-order R beats with fill back-pressure ----
        do_reset();
        for (int k = 0; k < 3; k++) begin
            miss_valid_i = 1'b1; miss_id_i = IW'(16'h30 + k); miss_addr_i = AW'(k + 1) << 20;
            @(negedge clk);
            chk($sformatf("ooo.ready%0d", k), miss_ready_o, 1'b1);
            if (k > 0) chk($sformatf("ooo.arid%0d", k - 1), mem_arid_o, EW'(k - 1));
            nxt();
        end
        miss_valid_i = 1'b0;
        @(negedge clk);
        chk("ooo.arid2", mem_arid_o, 2'd2);
        nxt();
        fill_ready_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rid_i = 2'd2; mem_rdata_i = DC2;
        miss_valid_i = 1'b1; miss_id_i = 16'h0033; miss_addr_i = 64'h40_0000;
        @(negedge clk);
        chk("ooo.alloc_with_r", miss_ready_o, 1'b1);
        nxt();
        miss_valid_i = 1'b0; mem_rid_i = 2'd0; mem_rdata_i = DC0;
        @(negedge clk);
        chk("ooo.arid3", mem_arid_o, 2'd3);
        chk("ooo.hold_tag0", fill_valid_o ? fill_tag_o : TW'(0), TW'(12'hC00));
        nxt();
        mem_rid_i = 2'd1; mem_rdata_i = DC1;
        @(negedge clk);
        chk("ooo.hold_tag1", fill_valid_o ? fill_tag_o : TW'(0), TW'(12'hC00));
        nxt();
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("ooo.hold_tag%0d", k + 2), fill_valid_o ? fill_tag_o : TW'(0), TW'(12'hC00));
            chk($sformatf("ooo.no_rsp%0d", k), rsp_valid_o, 1'b0);
            nxt();
        end
        fill_ready_i = 1'b1;
        nf = 0; nr = 0;
        for (int k = 0; k < 3; k++) begin
            ftags[k] = '0; fdatas[k] = '0; fill_cyc[k] = -1;
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                int e;
                e = int'(rsp_id_o) - 16'h30;
                nr++;
                if (e >= 0 && e < 3) begin
                    chk($sformatf("ooo.rsp%0d_after_fill", e), (fill_cyc[e] >= 0) && (fill_cyc[e] < cyc), 1'b1);
                    chk($sformatf("ooo.rsp%0d_data", e), rsp_data_o, (e == 0) ? DC0 : (e == 1) ? DC1 : DC2);
                end else begin
                    chk("ooo.rsp_id_range", rsp_id_o, 16'h0030);
                end
            end
            if (fill_valid_o) begin
                int e;
                e = int'(fill_tag_o >> 10) - 1;
                if (nf < 3) begin
                    ftags[nf] = fill_tag_o; fdatas[nf] = fill_data_o;
                end
                if (e >= 0 && e < 3) fill_cyc[e] = cyc;
                nf++;
            end
            nxt();
        end
        chk("ooo.fill_count", nf, 3);
        chk("ooo.rsp_count", nr, 3);
        chk("ooo.fill0_tag", ftags[0], TW'(12'hC00));
        chk("ooo.fill1_tag", ftags[1], TW'(12'h400));
        chk("ooo.fill2_tag", ftags[2], TW'(12'h800));
        chk("ooo.fill0_data", fdatas[0], DC2);
        chk("ooo.fill1_data", fdatas[1], DC0);
        chk("ooo.fill2_data", fdatas[2], DC1);

        // ---- unexpected R beats: idle entry, and after reset mid-WAIT ----
        do_reset();
        mem_rvalid_i = 1'b1; mem_rid_i = 2'd3; mem_rdata_i = D1;
        @(negedge clk);
        chk("err.same_cycle", err_o, 1'b0);
        nxt();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("err.pulse", err_o, 1'b1);
        chk("err.no_fill", fill_valid_o, 1'b0);
        nxt();
        @(negedge clk);
        chk("err.one_cycle", err_o, 1'b0);
        chk("err.no_fill_late", fill_valid_o, 1'b0);
        nxt();
        miss_valid_i = 1'b1; miss_id_i = 16'h0044; miss_addr_i = 64'h7000;
        @(negedge clk);
        nxt();
        miss_valid_i = 1'b0;
        @(negedge clk);
        chk("rstw.arvalid", mem_arvalid_o, 1'b1);
        nxt();
        @(negedge clk);
        chk("rstw.waiting", mem_arvalid_o, 1'b0);
        nxt();
        do_reset();
        mem_rvalid_i = 1'b1; mem_rid_i = 2'd0; mem_rdata_i = D1;
        @(negedge clk);
        chk("rstw.all_idle", miss_ready_o, 1'b1);
        nxt();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("rstw.err_pulse", err_o, 1'b1);
        chk("rstw.no_fill", fill_valid_o, 1'b0);
        nxt();
        @(negedge clk);
        chk("rstw.err_clear", err_o, 1'b0);
        chk("rstw.no_fill_late", fill_valid_o, 1'b0);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
